// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared scrub FSM encoding and default register file sizing
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write flags with issue/writeback/scrub updates
module rf_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set_en,
  input  logic [AW-1:0]    i_set_addr,
  input  logic             i_clr_en,
  input  logic [AW-1:0]    i_clr_addr,
  input  logic             i_scrub_en,
  input  logic [AW-1:0]    i_scrub_addr,
  output logic [NREGS-1:0] o_busy
);

  logic [NREGS-1:0] r_busy;

  // The set is applied after the clear so an issue wins over a same-address writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (i_scrub_en) begin
      r_busy[i_scrub_addr] <= 1'b0;
    end else begin
      if (i_clr_en) begin
        r_busy[i_clr_addr] <= 1'b0;
      end
      if (i_set_en && (i_set_addr != '0)) begin
        r_busy[i_set_addr] <= 1'b1;
      end
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/pipe_regfile.sv
// rtl/pipe_regfile.sv - multi-port register file with write bypass, hazard flags and register scrub
module pipe_regfile
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRP   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  input  logic                clr_req,
  output logic                clr_busy
);

  logic [XLEN-1:0] r_mem [NREGS];
  rf_state_e       r_state;
  rf_state_e       w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            w_clearing;
  logic            w_wr_ok;
  logic [NREGS-1:0] w_busy;

  assign w_clearing = (r_state == RF_CLEAR);
  assign w_wr_ok    = wr_en && !w_clearing && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RF_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Scrub walks registers 1..NREGS-1, one per cycle; register 0 is never stored.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RF_IDLE: begin
        if (clr_req) begin
          w_state_nxt = RF_CLEAR;
          w_cnt_nxt   = AW'(1);
        end
      end
      RF_CLEAR: begin
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == AW'(NREGS - 1)) begin
          w_state_nxt = RF_IDLE;
        end
      end
      default: w_state_nxt = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clearing) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set_en     (iss_en && !w_clearing),
    .i_set_addr   (iss_rd),
    .i_clr_en     (wr_en && !w_clearing),
    .i_clr_addr   (wr_addr),
    .i_scrub_en   (w_clearing),
    .i_scrub_addr (r_cnt),
    .o_busy       (w_busy)
  );

  genvar g;
  for (g = 0; g < NRP; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit;
    assign w_ra  = rd_addr[g*AW +: AW];
    assign w_hit = wr_en && (wr_addr == w_ra);
    assign rd_data[g*XLEN +: XLEN] = (w_ra == '0)             ? '0      :
                                     (w_hit && !w_clearing)   ? wr_data :
                                                                r_mem[w_ra];
    assign rd_busy[g] = !w_clearing && w_busy[w_ra] && !w_hit;
  end

  assign clr_busy = w_clearing;

endmodule

// File: tb/tb_pipe_regfile.sv
// tb/tb_pipe_regfile.sv - drives default and 64b/16-reg/3-port register files against a reference model
module tb_pipe_regfile;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  ra [3];
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        clr_req;

  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic         a_clr_busy;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_clr_busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  pipe_regfile u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data[31:0]),
    .rd_addr  ({ra[1], ra[0]}),
    .rd_data  (a_rd_data),
    .rd_busy  (a_rd_busy),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .clr_req  (clr_req),
    .clr_busy (a_clr_busy)
  );

  pipe_regfile #(.XLEN(64), .NREGS(16), .NRP(3)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr[3:0]),
    .wr_data  (wr_data),
    .rd_addr  ({ra[2][3:0], ra[1][3:0], ra[0][3:0]}),
    .rd_data  (b_rd_data),
    .rd_busy  (b_rd_busy),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd[3:0]),
    .clr_req  (clr_req),
    .clr_busy (b_clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state per configuration (0 = default, 1 = 64b/16 regs/3 ports).
  logic [63:0] m_reg  [2][32];
  bit          m_busy [2][32];
  bit          m_scrub[2];
  int          m_next [2];
  int          cfg_n  [2] = '{32, 16};
  int          cfg_p  [2] = '{2, 3};

  function automatic logic [63:0] dmask(int c);
    return (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] exp_data(int c, int p);
    int a = int'(ra[p]) % cfg_n[c];
    int w = int'(wr_addr) % cfg_n[c];
    if (a == 0) return 64'h0;
    if (!m_scrub[c] && wr_en && (w == a)) return wr_data & dmask(c);
    return m_reg[c][a];
  endfunction

  function automatic logic exp_busy(int c, int p);
    int a = int'(ra[p]) % cfg_n[c];
    int w = int'(wr_addr) % cfg_n[c];
    if (m_scrub[c]) return 1'b0;
    return m_busy[c][a] && !(wr_en && (w == a));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) begin
          m_reg[c][i]  = 64'h0;
          m_busy[c][i] = 1'b0;
        end
        m_scrub[c] = 1'b0;
      end else if (m_scrub[c]) begin
        m_reg[c][m_next[c]]  = 64'h0;
        m_busy[c][m_next[c]] = 1'b0;
        m_next[c]++;
        if (m_next[c] == cfg_n[c]) m_scrub[c] = 1'b0;
      end else begin
        int w  = int'(wr_addr) % cfg_n[c];
        int ir = int'(iss_rd) % cfg_n[c];
        if (wr_en && w != 0) begin
          m_reg[c][w]  = wr_data & dmask(c);
          m_busy[c][w] = 1'b0;
        end
        if (iss_en && ir != 0) m_busy[c][ir] = 1'b1;
        if (clr_req) begin
          m_scrub[c] = 1'b1;
          m_next[c]  = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] act;
    logic        actb;
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < cfg_p[c]; p++) begin
        act  = (c == 0) ? {32'h0, a_rd_data[p*32 +: 32]} : b_rd_data[p*64 +: 64];
        actb = (c == 0) ? a_rd_busy[p] : b_rd_busy[p];
        chk($sformatf("cfg%0d_rd_data%0d", c, p), act, exp_data(c, p));
        chk($sformatf("cfg%0d_rd_busy%0d", c, p), {63'h0, actb}, {63'h0, exp_busy(c, p)});
      end
      chk($sformatf("cfg%0d_clr_busy", c), {63'h0, (c == 0) ? a_clr_busy : b_clr_busy},
          {63'h0, m_scrub[c]});
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) compare_all();
  end

  task automatic idle();
    wr_en = 0; iss_en = 0; clr_req = 0;
  endtask

  task automatic set_ra(input logic [4:0] a);
    for (int p = 0; p < 3; p++) ra[p] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cnt_a;
  int cnt_b;
  bit done;

  initial begin
    rst_n = 0; wr_addr = 0; wr_data = 0; iss_rd = 0;
    set_ra(5'd0);
    idle();
    step();
    chk_on = 1;
    step();
    @(negedge clk);
    chk("reset_rd_data", a_rd_data, 64'h0);
    chk("reset_clr_busy", {63'h0, a_clr_busy | b_clr_busy}, 64'h0);
    step();
    rst_n = 1;
    step();

    // Bypass
    wr_en = 1; wr_addr = 5; wr_data = 64'hCAFEF00D_DEADBEEF; set_ra(5'd5);
    @(negedge clk);
    chk("bypass_a", {32'h0, a_rd_data[31:0]}, 64'h0000_0000_DEADBEEF);
    chk("bypass_b_p2", b_rd_data[191:128], 64'hCAFEF00D_DEADBEEF);
    step();
    idle();
    @(negedge clk);
    chk("after_write_a", {32'h0, a_rd_data[63:32]}, 64'h0000_0000_DEADBEEF);
    step();

    // Register 0 protection
    wr_en = 1; wr_addr = 0; wr_data = 64'h1234; set_ra(5'd0);
    @(negedge clk);
    chk("x0_bypass", {32'h0, a_rd_data[31:0]}, 64'h0);
    step();
    idle(); iss_en = 1; iss_rd = 0;
    step();
    idle();
    @(negedge clk);
    chk("x0_busy", {61'h0, b_rd_busy}, 64'h0);
    step();

    // Scoreboard hazard
    iss_en = 1; iss_rd = 7; set_ra(5'd7);
    step();
    idle();
    repeat (3) step();
    @(negedge clk);
    chk("busy_set_a", {62'h0, a_rd_busy}, 64'h3);
    chk("busy_set_b", {61'h0, b_rd_busy}, 64'h7);
    step();
    wr_en = 1; wr_addr = 7; wr_data = 64'h77;
    @(negedge clk);
    chk("busy_release", {62'h0, a_rd_busy}, 64'h0);
    step();
    idle();
    @(negedge clk);
    chk("busy_cleared", {61'h0, b_rd_busy}, 64'h0);
    step();

    // Issue and writeback on the same register
    iss_en = 1; wr_en = 1; iss_rd = 9; wr_addr = 9; wr_data = 64'h99; set_ra(5'd9);
    step();
    idle();
    @(negedge clk);
    chk("collide_data", {32'h0, a_rd_data[31:0]}, 64'h99);
    chk("collide_busy", {63'h0, a_rd_busy[0]}, 64'h1);
    step();

    // Scrub with leftover hazard on x3 and writes attempted mid-scrub
    iss_en = 1; iss_rd = 3;
    step();
    idle();
    for (int i = 1; i < 32; i++) begin
      wr_en = 1; wr_addr = 5'(i);
      wr_data = {32'hA5A5_0000 | 32'(i), 32'h5A5A_0000 | 32'(i)};
      step();
    end
    idle(); clr_req = 1; set_ra(5'd1);
    step();
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (k < 14) begin
        wr_en = 1; wr_addr = 5'(k + 1); wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        iss_en = 1; iss_rd = 5'(k + 2);
      end
      clr_req = (k == 5);
      set_ra(5'(k % 32));
      @(negedge clk);
      cnt_a += int'(a_clr_busy);
      cnt_b += int'(b_clr_busy);
      step();
    end
    idle();
    chk("scrub_len_a", 64'(cnt_a), 64'd31);
    chk("scrub_len_b", 64'(cnt_b), 64'd15);
    for (int i = 0; i < 32; i++) begin
      set_ra(5'(i));
      @(negedge clk);
      chk("scrub_zero_a", {32'h0, a_rd_data[31:0]}, 64'h0);
      chk("scrub_zero_b", b_rd_data[191:128], 64'h0);
      step();
    end

    // Simultaneous write, issue and scrub start, then reset mid-scrub
    wr_en = 1; wr_addr = 12; wr_data = 64'h0BAD_F00D_1200_0012;
    step();
    wr_en = 1; wr_addr = 4; wr_data = 64'h44; iss_en = 1; iss_rd = 6; clr_req = 1;
    step();
    idle(); set_ra(5'd4);
    @(negedge clk);
    chk("concurrent_write", {32'h0, a_rd_data[31:0]}, 64'h44);
    chk("concurrent_scrub", {63'h0, a_clr_busy}, 64'h1);
    repeat (9) step();
    rst_n = 0;
    step();
    rst_n = 1; set_ra(5'd12);
    @(negedge clk);
    chk("rst_mid_scrub_busy", {62'h0, a_clr_busy, b_clr_busy}, 64'h0);
    chk("rst_mid_scrub_reg", b_rd_data[63:0], 64'h0);
    step();
    clr_req = 1;
    step();
    idle();
    @(negedge clk);
    chk("rescrub_start", {62'h0, a_clr_busy, b_clr_busy}, 64'h3);
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      @(negedge clk);
      done = !a_clr_busy && !b_clr_busy;
    end
    chk("rescrub_done", {63'h0, done}, 64'h1);
    step();

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_regfile.md
PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning the register count; it is a power of 2 and at least 4.
REQ-003 SHALL have parameter NRP, default 2, meaning the number of read ports (1..4).
REQ-004 SHALL have derived localparam AW = $clog2(NREGS).
REQ-005 SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  sole clock; all state updates on its rising edge.
  rst_n  in  1  synchronous, active-low reset.
  wr_en  in  1  writeback strobe.
  wr_addr  in  AW  writeback destination.
  wr_data  in  XLEN  writeback value.
  rd_addr  in  NRP*AW  packed read addresses; port p uses slice [p*AW +: AW].
  rd_data  out  NRP*XLEN  packed read data.
  rd_busy  out  NRP  per-port flag: a pending write to that address is outstanding.
  iss_en  in  1  issue strobe; marks iss_rd as pending.
  iss_rd  in  AW  destination of the issuing instruction.
  clr_req  in  1  one-cycle request to start a sequential register scrub.
  clr_busy  out  1  high while the scrub runs.

Function
REQ-006 SHALL treat register 0 as constant zero: reads return 0, writes to it are dropped, and its busy flag stays 0.
REQ-007 SHALL perform reads combinationally, with zero latency.
REQ-008 SHALL bypass write to read: if wr_en=1, wr_addr=rd_addr[p] and the address is nonzero, rd_data[p] returns wr_data in the same cycle.
REQ-009 SHALL update the array one edge after wr_en=1 with nonzero wr_addr; the write is visible without bypass from the next cycle.
REQ-010 SHALL set busy[iss_rd] on the edge after iss_en=1, unless iss_rd=0.
REQ-011 SHALL clear busy[wr_addr] on the edge after wr_en=1.
REQ-012 SHALL give set priority when iss_en and wr_en target the same address in one cycle: busy ends 1 and the data is still written.
REQ-013 SHALL drive rd_busy[p] = busy[rd_addr[p]] AND NOT (wr_en AND wr_addr=rd_addr[p]); the same-cycle writeback releases the hazard.
REQ-014 SHALL implement a scrub FSM with two states, IDLE and CLEAR.
  IDLE -> CLEAR when clr_req=1; the counter loads 1.
REQ-015 SHALL, in CLEAR, on each edge: zero reg[cnt], clear busy[cnt], and increment cnt.
  When cnt=NREGS-1, it completes that register and returns to IDLE.
  A scrub therefore takes exactly NREGS-1 cycles.
REQ-016 SHALL drive clr_busy=1 exactly while the state is CLEAR.
REQ-017 SHALL, while in CLEAR:
  ignore wr_en and iss_en (no array or busy update);
  disable the bypass;
  return current array contents on reads;
  force rd_busy to 0.
REQ-018 SHALL ignore clr_req while in CLEAR.
REQ-019 SHALL accept wr_en, iss_en and clr_req all asserted in IDLE in one cycle: the write and issue take effect and the scrub starts on the same edge.

Reset
REQ-020 SHALL, on an edge with rst_n=0:
  zero all registers;
  clear all busy flags;
  set the state to IDLE and cnt to 0.
REQ-021 SHALL give reset priority over every other input, including a reset mid-scrub, after which clr_busy=0 on the next cycle.
REQ-022 SHALL drive these output values during and after reset: rd_data=0, rd_busy=0, clr_busy=0.

Structure
REQ-023 SHALL place the FSM state enum (RF_IDLE, RF_CLEAR) and the default XLEN/NREGS constants in shared package regfile_pkg.
REQ-024 SHALL implement the busy-bit array and its set/clear/priority logic in one sub-module, rf_scoreboard; the data array, bypass and FSM stay in pipe_regfile.

Verification
REQ-025 SHALL cover these scenarios with the default parameters:
  Bypass: write x5=0xDEADBEEF with rd_addr0=5 in the same cycle -> rd_data0=0xDEADBEEF that cycle, and still after wr_en drops.
  x0 protection: wr_en with wr_addr=0, data 0x1234 -> rd_data reads 0 at addr 0; iss_rd=0 -> rd_busy stays 0.
  Scoreboard: iss x7, then 3 idle cycles -> rd_busy=1; write x7 -> rd_busy=0 that same cycle, and 0 afterward.
  Collision: iss_en and wr_en on x9 in one cycle -> x9 data updated and busy=1 on the next cycle.
  Scrub: fill x1..x31 with nonzero values, then pulse clr_req -> clr_busy high for 31 cycles; writes during that window are dropped; all reads return 0 afterward.
  Reset mid-scrub: rst_n=0 at cycle 10 of a scrub -> clr_busy=0, all regs 0, and a new clr_req is accepted.
REQ-026 SHALL repeat the scenarios with XLEN=64, NREGS=16, NRP=3, checking all three read ports.
